// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
// Quotient goes to LO, remainder to HI. busy stalls the pipeline while the
// divide runs; done pulses for one cycle when the result registers update.
//
// Optional feature: define DIV_FAST_PATH_EN to finish zero-operand divides
// (opa==0 or opb==0) directly from IDLE without iterating.
//
// Handshake: start is sampled only in IDLE (with flush low); the requester
// holds it until busy falls. done is a one-cycle pulse in DONE; quotient and
// remainder hold their value until the next result is produced.
// fsm_state exposes the FSM encoding (0 IDLE, 1 CALC, 2 SIGN, 3 DONE).

module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             signed_div,
    input  logic             flush,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   dvd;
    logic [WIDTH-1:0]   divisor;
    logic [CNT_W-1:0]   counter;
    logic               sign_q;
    logic               sign_r;
    logic               is_signed;

    logic [WIDTH-1:0]   opa_abs;
    logic [WIDTH-1:0]   opb_abs;
    logic [WIDTH:0]     shifted;
    logic [WIDTH-1:0]   sub;
    logic               take;
    logic [WIDTH-1:0]   rem_next;
    logic               fast_hit;
    logic [WIDTH-1:0]   fast_q;
    logic [WIDTH-1:0]   fast_r;

    assign fsm_state = state;

    // Operand magnitudes, one restoring step, and the zero-operand shortcut results
    always_comb begin
        opa_abs  = (signed_div && opa[WIDTH-1]) ? -opa : opa;
        opb_abs  = (signed_div && opb[WIDTH-1]) ? -opb : opb;
        // Compare at WIDTH+1 bits; when the subtract is taken the true
        // difference always fits in WIDTH bits, so a WIDTH-bit subtract suffices.
        shifted  = {rem, dvd[WIDTH-1]};
        take     = (shifted >= {1'b0, divisor});
        sub      = shifted[WIDTH-1:0] - divisor;
        rem_next = take ? sub : shifted[WIDTH-1:0];
`ifdef DIV_FAST_PATH_EN
        fast_hit = (opa == '0) || (opb == '0);
`else
        fast_hit = 1'b0;
`endif
        // Divide-by-zero takes priority so 0/0 matches the iterative result.
        if (opb == '0) begin
            fast_q = (signed_div && opa[WIDTH-1]) ? WIDTH'(1) : '1;
            fast_r = opa;
        end else begin
            fast_q = '0;
            fast_r = '0;
        end
    end

    // Control FSM with registered busy/done and result registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            rem       <= '0;
            dvd       <= '0;
            divisor   <= '0;
            counter   <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            is_signed <= 1'b0;
        end else if (flush) begin
            // Cancel wins over everything, including a same-cycle start.
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (fast_hit) begin
                            quotient  <= fast_q;
                            remainder <= fast_r;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            state     <= DONE;
                        end else begin
                            rem       <= '0;
                            dvd       <= opa_abs;
                            divisor   <= opb_abs;
                            counter   <= '0;
                            is_signed <= signed_div;
                            sign_q    <= opa[WIDTH-1] ^ opb[WIDTH-1];
                            sign_r    <= opa[WIDTH-1];
                            busy      <= 1'b1;
                            state     <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem     <= rem_next;
                    dvd     <= {dvd[WIDTH-2:0], take};
                    counter <= counter + 1'b1;
                    if (counter == CNT_W'(WIDTH - 1)) begin
                        state <= SIGN;
                    end
                end
                SIGN: begin
                    quotient  <= (is_signed && sign_q) ? -dvd : dvd;
                    remainder <= (is_signed && sign_r) ? -rem : rem;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed bench for div_unit with hand-computed results,
// latency/busy counting, flush and asynchronous reset scenarios.

module tb_div_unit;

    logic        clk;
    logic        resetn;
    logic        start;
    logic        signed_div;
    logic        flush;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic [1:0]  fsm_state;

    int checks   = 0;
    int failures = 0;

`ifdef DIV_FAST_PATH_EN
    localparam int ZLAT  = 1;
    localparam int ZBUSY = 0;
`else
    localparam int ZLAT  = 34;
    localparam int ZBUSY = 33;
`endif

    div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .signed_div (signed_div),
        .flush      (flush),
        .opa        (opa),
        .opb        (opb),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .fsm_state  (fsm_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one divide from a negedge, measure latency and busy cycles, check result.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sg,
                           input logic [31:0] eq, input logic [31:0] er,
                           input int exp_lat, input int exp_busy, input string tag);
        int lat;
        int busy_cnt;
        bit seen;
        opa = a; opb = b; signed_div = sg; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 1; busy_cnt = 0; seen = 1'b0;
        while (!seen && lat <= 100) begin
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) seen = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
        check({tag, "_quotient"}, quotient, eq);
        check({tag, "_remainder"}, remainder, er);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        check({tag, "_quotient_hold"}, quotient, eq);
    endtask

    initial begin
        int cnt_done;
        int cnt_busy;
        int lat;
        bit seen;

        resetn = 1'b0; start = 1'b0; signed_div = 1'b0; flush = 1'b0;
        opa = '0; opb = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_quotient", quotient, 32'd0);
        check("reset_remainder", remainder, 32'd0);
        check("reset_state", 32'(fsm_state), 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        run_div(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 34, 33, "divu_100_7");
        run_div(32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 34, 33, "div_m7_2");
        run_div(32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1, 34, 33, "div_7_m2");
        run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 34, 33, "div_ovf");
        run_div(32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0, 32'h80000000, 34, 33, "divu_ovf");
        run_div(32'd5, 32'd0, 1'b0, 32'hFFFFFFFF, 32'd5, ZLAT, ZBUSY, "divu_5_0");
        run_div(32'd0, 32'd9, 1'b0, 32'd0, 32'd0, ZLAT, ZBUSY, "divu_0_9");
        run_div(32'hFFFFFFFB, 32'd0, 1'b1, 32'd1, 32'hFFFFFFFB, ZLAT, ZBUSY, "div_m5_0");

        // Flush on cycle 10 of a divide: no result, previous result held.
        opa = 32'd100; opb = 32'd7; signed_div = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_done", 32'(done), 32'd0);
        check("flush_state", 32'(fsm_state), 32'd0);
        cnt_done = 0; cnt_busy = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) cnt_done++;
            if (busy === 1'b1) cnt_busy++;
            @(negedge clk);
        end
        check("flush_no_done", 32'(cnt_done), 32'd0);
        check("flush_no_busy", 32'(cnt_busy), 32'd0);
        check("flush_quotient_kept", quotient, 32'd1);
        check("flush_remainder_kept", remainder, 32'hFFFFFFFB);
        run_div(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 34, 33, "divu_9_3");

        // Flush together with start in IDLE: start is not accepted.
        opa = 32'd50; opb = 32'd5; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", 32'(busy), 32'd0);
        check("flush_start_state", 32'(fsm_state), 32'd0);
        @(negedge clk);

        // Asynchronous reset at cycle 20 of a divide.
        opa = 32'd100; opb = 32'd7; signed_div = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        check("midop_busy", 32'(busy), 32'd1);
        resetn = 1'b0;
        #1;
        check("async_busy", 32'(busy), 32'd0);
        check("async_done", 32'(done), 32'd0);
        check("async_quotient", quotient, 32'd0);
        check("async_remainder", remainder, 32'd0);
        check("async_state", 32'(fsm_state), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Start reasserted with other operands while busy must be ignored.
        opa = 32'd200; opb = 32'd10; signed_div = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 1; seen = 1'b0;
        while (!seen && lat <= 100) begin
            if (done === 1'b1) seen = 1'b1;
            else begin
                if (lat == 5) begin
                    opa = 32'd50; opb = 32'd3; signed_div = 1'b1; start = 1'b1;
                end
                if (lat == 8) start = 1'b0;
                @(negedge clk);
                lat++;
            end
        end
        start = 1'b0;
        check("ignore_done_seen", 32'(seen), 32'd1);
        check("ignore_latency", 32'(lat), 32'd34);
        check("ignore_quotient", quotient, 32'd20);
        check("ignore_remainder", remainder, 32'd0);
        @(negedge clk);
        check("ignore_back_idle", 32'(fsm_state), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU in the EX stage.
- Consumes the two operands delivered by the ID-stage register file and bypass network.
- Returns the quotient for LO and the remainder for HI.
- Holds the pipeline via busy until the result is ready.

Parameters:
- WIDTH, 32, operand/result width; 32 is the only supported value.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- start  input  1  request a divide; sampled only in IDLE.
- signed_div  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- flush  input  1  cancel the operation (exception/eret); synchronous.
- opa  input  WIDTH  dividend (rs); sampled with start.
- opb  input  WIDTH  divisor (rt); sampled with start.
- busy  output  1  divide in progress; EX drives stallreq from it.
- done  output  1  one-cycle pulse; result valid.
- quotient  output  WIDTH  quotient to LO.
- remainder  output  WIDTH  remainder to HI.

Behaviour:
- Reset: one clock domain (clk). resetn is asynchronous, active-low; both polarity and synchronicity are fixed. While resetn=0:
  - state=IDLE;
  - busy=0, done=0;
  - quotient=0, remainder=0;
  - counter, working registers and latched sign bits = 0.
- States: IDLE, CALC, SIGN, DONE.
- IDLE:
  - start=1 and flush=0 at edge E: latch |opa| and |opb| (absolute values only when signed_div=1), sign_q = opa[31]^opb[31], sign_r = opa[31], counter=0; go to CALC.
  - start while not in IDLE is ignored; the requester holds start until busy falls.
- CALC: one step per edge.
  - Shift {rem, dvd} left 1.
  - If rem >= divisor: rem -= divisor and shift in a quotient bit of 1; otherwise shift in 0.
  - Compare and subtract at WIDTH+1 bits.
  - After step 32 (edge E+32), go to SIGN.
- SIGN, edge E+33:
  - quotient = sign_q ? -q : q;
  - remainder = sign_r ? -rem : rem;
  - sign correction applies only if the latched signed_div=1;
  - go to DONE.
- DONE:
  - done=1 for exactly this cycle, the cycle after edge E+33;
  - next edge returns to IDLE;
  - a start during DONE is ignored.
- busy=1 in CALC and SIGN, 0 in IDLE and DONE.
- quotient and remainder change only on the SIGN edge or the fast-path edge. They hold their value until the next result (HI/LO write may lag).
- Overflow case, 0x80000000 / -1 signed: quotient=0x80000000, remainder=0. No trap.
- Divide by zero: the iteration result is kept as defined behaviour.
  - Unsigned: quotient=0xFFFFFFFF, remainder=opa.
  - Signed: quotient = opa<0 ? 1 : 0xFFFFFFFF, remainder=opa.
- Flush:
  - In any state, the next edge goes to IDLE with done=0 and busy=0; no result update.
  - Flush and start together in IDLE: flush wins, start not accepted.
  - Flush in DONE: done still shows its current cycle; outputs are already updated.
- resetn low mid-operation: immediate return to reset values; no done.

Optional Feature:
- Macro DIV_FAST_PATH_EN.
- When defined, at the start edge E with opb==0 or opa==0, go directly to DONE with final results registered on edge E.
  - done is high in the cycle after edge E.
  - busy stays 0.
  - Results are bit-identical to the full path: opa==0 gives quotient=0, remainder=0; opb==0 follows the divide-by-zero rule above.
- When not defined, every divide takes the full 34-cycle path.

Test Plan:
- DIVU 100/7 → done exactly one cycle, 34 cycles after the start edge; quotient=14 (0x0E), remainder=2; busy high 33 cycles.
- DIV 0xFFFFFFF9 (-7) / 2 → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. DIV 7 / 0xFFFFFFFE → quotient=0xFFFFFFFD, remainder=1.
- DIV 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0. DIVU same operands → quotient=0, remainder=0x80000000.
- DIVU 5/0 → quotient=0xFFFFFFFF, remainder=5. DIV 0xFFFFFFFB / 0 → quotient=1, remainder=0xFFFFFFFB. With DIV_FAST_PATH_EN: same values, done in cycle 2, busy never high.
- Start 100/7, assert flush on cycle 10 → busy=0 next cycle, no done pulse, outputs keep the previous result. An immediate new start of 9/3 → quotient=3, remainder=0 after the normal latency.
- Drive resetn=0 at cycle 20 of a divide → busy, done, quotient and remainder go to 0 asynchronously. After release, start ignored during busy is checked; a new start completes normally.
